// File: rtl/ysyx_22050039_idu_stage.sv
// Decode stage for the ysyx_22050039 RV64 core: decodes one instruction per cycle, reads the
// register file with write-back bypass, tracks pending writes in a scoreboard, registers the bundle.
module ysyx_22050039_idu_stage #(
    parameter int XLEN     = 64,
    parameter int INST_LEN = 32,
    parameter int NR_REG   = 32,
    parameter int REG_SEL  = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [INST_LEN-1:0] in_inst,
    input  logic [XLEN-1:0]     in_pc,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [XLEN-1:0]     out_pc,
    output logic [XLEN-1:0]     out_src1,
    output logic [XLEN-1:0]     out_src2,
    output logic [XLEN-1:0]     out_imm,
    output logic [REG_SEL-1:0]  out_rd,
    output logic                out_rd_wen,
    output logic [5:0]          out_fmt,
    output logic [6:0]          out_opcode,
    output logic [2:0]          out_funct3,
    output logic [6:0]          out_funct7,
    output logic                out_ebreak,
    output logic                out_illegal,
    input  logic                wb_en,
    input  logic [REG_SEL-1:0]  wb_rd,
    input  logic [XLEN-1:0]     wb_data,
    input  logic                flush
);

    logic [XLEN-1:0]    r_regs [NR_REG];
    logic [NR_REG-1:0]  r_busy;
    logic               r_out_valid;
    logic               r_out_rd_wen;
    logic [REG_SEL-1:0] r_out_rd;

    logic [6:0]         w_opcode;
    logic [REG_SEL-1:0] w_rd, w_rs1, w_rs2;
    logic [5:0]         w_fmt;
    logic [XLEN-1:0]    w_imm;
    logic               w_rs1_used, w_rs2_used, w_wr_rd, w_illegal, w_ebreak;
    logic               w_rd_wen, w_byp1, w_byp2, w_hazard, w_accept;
    logic [XLEN-1:0]    w_val1, w_val2, w_src1, w_src2;
    logic [NR_REG-1:0]  w_one, w_wb_mask, w_fl_mask, w_set_mask, w_busy_nxt;

    assign w_opcode = in_inst[6:0];
    assign w_rd     = in_inst[11:7];
    assign w_rs1    = in_inst[19:15];
    assign w_rs2    = in_inst[24:20];

    // Format, immediate and operand-usage decode
    always_comb begin
        w_fmt      = 6'b000000;
        w_imm      = {XLEN{1'b0}};
        w_rs1_used = 1'b0;
        w_rs2_used = 1'b0;
        w_wr_rd    = 1'b0;
        w_illegal  = 1'b0;
        w_ebreak   = 1'b0;
        case (w_opcode)
            7'b0110111, 7'b0010111: begin
                w_fmt   = 6'b000010;
                w_imm   = {{(XLEN-32){in_inst[31]}}, in_inst[31:12], 12'b0};
                w_wr_rd = 1'b1;
            end
            7'b1101111: begin
                w_fmt   = 6'b000001;
                w_imm   = {{(XLEN-20){in_inst[31]}}, in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};
                w_wr_rd = 1'b1;
            end
            7'b1100111, 7'b0000011, 7'b0010011, 7'b0011011: begin
                w_fmt      = 6'b010000;
                w_imm      = {{(XLEN-12){in_inst[31]}}, in_inst[31:20]};
                w_rs1_used = 1'b1;
                w_wr_rd    = 1'b1;
            end
            7'b0100011: begin
                w_fmt      = 6'b001000;
                w_imm      = {{(XLEN-12){in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
                w_rs1_used = 1'b1;
                w_rs2_used = 1'b1;
            end
            7'b1100011: begin
                w_fmt      = 6'b000100;
                w_imm      = {{(XLEN-12){in_inst[31]}}, in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
                w_rs1_used = 1'b1;
                w_rs2_used = 1'b1;
            end
            7'b0110011, 7'b0111011: begin
                w_fmt      = 6'b100000;
                w_rs1_used = 1'b1;
                w_rs2_used = 1'b1;
                w_wr_rd    = 1'b1;
            end
            7'b1110011: begin
                if (in_inst == 32'h0010_0073) begin
                    w_ebreak = 1'b1;
                end else begin
                    w_illegal = 1'b1;
                end
            end
            default: w_illegal = 1'b1;
        endcase
    end

    assign w_rd_wen = w_wr_rd & (w_rd != {REG_SEL{1'b0}});

    // Write-back forwarding makes a value visible in the same cycle it is written
    assign w_byp1 = wb_en & (wb_rd == w_rs1) & (w_rs1 != {REG_SEL{1'b0}});
    assign w_byp2 = wb_en & (wb_rd == w_rs2) & (w_rs2 != {REG_SEL{1'b0}});
    assign w_val1 = (w_rs1 == {REG_SEL{1'b0}}) ? {XLEN{1'b0}} : (w_byp1 ? wb_data : r_regs[w_rs1]);
    assign w_val2 = (w_rs2 == {REG_SEL{1'b0}}) ? {XLEN{1'b0}} : (w_byp2 ? wb_data : r_regs[w_rs2]);
    assign w_src1 = w_rs1_used ? w_val1 : {XLEN{1'b0}};
    assign w_src2 = w_rs2_used ? w_val2 : {XLEN{1'b0}};

    assign w_hazard = (w_rs1_used & r_busy[w_rs1] & ~w_byp1)
                    | (w_rs2_used & r_busy[w_rs2] & ~w_byp2)
                    | (w_rd_wen & r_busy[w_rd] & ~(wb_en & (wb_rd == w_rd)));

    assign in_ready = rst & (~r_out_valid | out_ready) & ~w_hazard & ~flush;
    assign w_accept = in_valid & in_ready;

    // Scoreboard: clears from write-back and flush, then a same-index accept wins
    assign w_one      = {{(NR_REG-1){1'b0}}, 1'b1};
    assign w_wb_mask  = wb_en ? (w_one << wb_rd) : {NR_REG{1'b0}};
    assign w_fl_mask  = (flush & r_out_valid & r_out_rd_wen) ? (w_one << r_out_rd) : {NR_REG{1'b0}};
    assign w_set_mask = (w_accept & w_rd_wen) ? (w_one << w_rd) : {NR_REG{1'b0}};
    assign w_busy_nxt = ((r_busy & ~w_wb_mask & ~w_fl_mask) | w_set_mask) & ~w_one;

    // Scoreboard register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_busy <= {NR_REG{1'b0}};
        end else begin
            r_busy <= w_busy_nxt;
        end
    end

    // Register file, x0 never written
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NR_REG; i++) begin
                r_regs[i] <= {XLEN{1'b0}};
            end
        end else if (wb_en && (wb_rd != {REG_SEL{1'b0}})) begin
            r_regs[wb_rd] <= wb_data;
        end
    end

    // Output bundle register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_out_valid  <= 1'b0;
            r_out_rd     <= {REG_SEL{1'b0}};
            r_out_rd_wen <= 1'b0;
            out_pc       <= {XLEN{1'b0}};
            out_src1     <= {XLEN{1'b0}};
            out_src2     <= {XLEN{1'b0}};
            out_imm      <= {XLEN{1'b0}};
            out_fmt      <= 6'b000000;
            out_opcode   <= 7'b0000000;
            out_funct3   <= 3'b000;
            out_funct7   <= 7'b0000000;
            out_ebreak   <= 1'b0;
            out_illegal  <= 1'b0;
        end else if (w_accept) begin
            r_out_valid  <= 1'b1;
            r_out_rd     <= w_rd;
            r_out_rd_wen <= w_rd_wen;
            out_pc       <= in_pc;
            out_src1     <= w_src1;
            out_src2     <= w_src2;
            out_imm      <= w_imm;
            out_fmt      <= w_fmt;
            out_opcode   <= w_opcode;
            out_funct3   <= in_inst[14:12];
            out_funct7   <= in_inst[31:25];
            out_ebreak   <= w_ebreak;
            out_illegal  <= w_illegal;
        end else if (flush || out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid  = r_out_valid;
    assign out_rd     = r_out_rd;
    assign out_rd_wen = r_out_rd_wen;

endmodule

// File: tb/tb_ysyx_22050039_idu_stage.sv
// Directed bench for the decode stage: reset, RAW stall with bypass, backpressure, flush,
// immediate formats and illegal/ebreak decode.
module tb_ysyx_22050039_idu_stage;

    logic        clk, rst;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_inst;
    logic [63:0] in_pc, out_pc, out_src1, out_src2, out_imm, wb_data;
    logic [4:0]  out_rd, wb_rd;
    logic        out_rd_wen, out_ebreak, out_illegal, wb_en, flush;
    logic [5:0]  out_fmt;
    logic [6:0]  out_opcode, out_funct7;
    logic [2:0]  out_funct3;

    int n_checks = 0;
    int n_errors = 0;

    ysyx_22050039_idu_stage dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_src1(out_src1), .out_src2(out_src2), .out_imm(out_imm),
        .out_rd(out_rd), .out_rd_wen(out_rd_wen), .out_fmt(out_fmt),
        .out_opcode(out_opcode), .out_funct3(out_funct3), .out_funct7(out_funct7),
        .out_ebreak(out_ebreak), .out_illegal(out_illegal),
        .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data), .flush(flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // jal x0,-4 / sd x1,-8(x0) / all-zero / ebreak / beq x0,x0,+8
    logic [31:0] v_inst    [5] = '{32'hFFDF_F06F, 32'hFE10_3C23, 32'h0000_0000, 32'h0010_0073, 32'h0000_0463};
    logic [63:0] v_imm     [5] = '{64'hFFFF_FFFF_FFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFF8, 64'h0, 64'h0, 64'h8};
    logic [5:0]  v_fmt     [5] = '{6'b000001, 6'b001000, 6'b000000, 6'b000000, 6'b000100};
    logic [63:0] v_src2    [5] = '{64'h0, 64'h7, 64'h0, 64'h0, 64'h0};
    logic        v_illegal [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic        v_ebreak  [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    initial begin
        rst = 1'b0; in_valid = 1'b0; in_inst = 32'h0; in_pc = 64'h0;
        out_ready = 1'b1; wb_en = 1'b0; wb_rd = 5'd0; wb_data = 64'h0; flush = 1'b0;
        #2;
        in_valid = 1'b1; in_inst = 32'hFFF0_0093; in_pc = 64'h1000;
        #1;
        check("rst_valid", {63'b0, out_valid}, 64'h0);
        check("rst_ready", {63'b0, in_ready}, 64'h0);
        check("rst_imm", out_imm, 64'h0);
        #9;
        rst = 1'b1;
        #1;
        check("addi_ready", {63'b0, in_ready}, 64'h1);
        tick();
        check("addi_valid", {63'b0, out_valid}, 64'h1);
        check("addi_imm", out_imm, 64'hFFFF_FFFF_FFFF_FFFF);
        check("addi_fmt", {58'b0, out_fmt}, 64'h10);
        check("addi_rd", {59'b0, out_rd}, 64'h1);
        check("addi_rdwen", {63'b0, out_rd_wen}, 64'h1);
        check("addi_pc", out_pc, 64'h1000);
        check("addi_opc", {57'b0, out_opcode}, 64'h13);

        // add x2,x1,x1 must stall on busy x1
        in_inst = 32'h0010_8133; in_pc = 64'h1004;
        #1;
        check("raw_stall", {63'b0, in_ready}, 64'h0);
        tick();
        check("raw_drained", {63'b0, out_valid}, 64'h0);
        wb_en = 1'b1; wb_rd = 5'd1; wb_data = 64'h7;
        #1;
        check("raw_release", {63'b0, in_ready}, 64'h1);
        tick();
        wb_en = 1'b0;
        check("raw_src1", out_src1, 64'h7);
        check("raw_src2", out_src2, 64'h7);
        check("raw_rd", {59'b0, out_rd}, 64'h2);
        check("raw_fmt", {58'b0, out_fmt}, 64'h20);

        // addi x5,x1,3 under backpressure
        out_ready = 1'b0; in_inst = 32'h0030_8293; in_pc = 64'h1008;
        #1;
        check("bp_ready0", {63'b0, in_ready}, 64'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bp_valid", {63'b0, out_valid}, 64'h1);
            check("bp_rd", {59'b0, out_rd}, 64'h2);
            check("bp_src1", out_src1, 64'h7);
            check("bp_ready", {63'b0, in_ready}, 64'h0);
        end
        out_ready = 1'b1;
        #1;
        check("bp_resume", {63'b0, in_ready}, 64'h1);
        tick();
        check("bp_next_rd", {59'b0, out_rd}, 64'h5);
        check("bp_next_src1", out_src1, 64'h7);
        check("bp_next_imm", out_imm, 64'h3);

        // lui x3 then flush it, then add x4,x3,x0 must not stall
        in_inst = 32'h1234_51B7; in_pc = 64'h100C;
        #1;
        check("lui_ready", {63'b0, in_ready}, 64'h1);
        tick();
        check("lui_imm", out_imm, 64'h1234_5000);
        check("lui_fmt", {58'b0, out_fmt}, 64'h2);
        check("lui_rd", {59'b0, out_rd}, 64'h3);
        in_valid = 1'b0; out_ready = 1'b0; flush = 1'b1;
        #1;
        check("flush_ready", {63'b0, in_ready}, 64'h0);
        tick();
        check("flush_valid", {63'b0, out_valid}, 64'h0);
        flush = 1'b0; out_ready = 1'b1; in_valid = 1'b1; in_inst = 32'h0001_8233; in_pc = 64'h1010;
        #1;
        check("flush_nostall", {63'b0, in_ready}, 64'h1);
        tick();
        check("flush_add_rd", {59'b0, out_rd}, 64'h4);
        check("flush_add_src1", out_src1, 64'h0);

        for (int i = 0; i < 5; i++) begin
            in_inst = v_inst[i];
            #1;
            check("vec_ready", {63'b0, in_ready}, 64'h1);
            tick();
            check("vec_imm", out_imm, v_imm[i]);
            check("vec_fmt", {58'b0, out_fmt}, {58'b0, v_fmt[i]});
            check("vec_src2", out_src2, v_src2[i]);
            check("vec_rdwen", {63'b0, out_rd_wen}, 64'h0);
            check("vec_illegal", {63'b0, out_illegal}, {63'b0, v_illegal[i]});
            check("vec_ebreak", {63'b0, out_ebreak}, {63'b0, v_ebreak[i]});
        end

        // write x5, hold a bundle, then reset mid-stream
        in_inst = 32'h0000_0463; wb_en = 1'b1; wb_rd = 5'd5; wb_data = 64'h55;
        tick();
        wb_en = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        check("pre_rst_valid", {63'b0, out_valid}, 64'h1);
        #2;
        rst = 1'b0;
        #1;
        check("mid_rst_valid", {63'b0, out_valid}, 64'h0);
        check("mid_rst_pc", out_pc, 64'h0);
        check("mid_rst_ready", {63'b0, in_ready}, 64'h0);
        #2;
        rst = 1'b1; out_ready = 1'b1; in_valid = 1'b1; in_inst = 32'h0002_8333;
        #1;
        check("post_rst_ready", {63'b0, in_ready}, 64'h1);
        tick();
        check("post_rst_src1", out_src1, 64'h0);
        check("post_rst_rd", {59'b0, out_rd}, 64'h6);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/ysyx_22050039_idu_stage.md
# ysyx_22050039_idu_stage

Pipelined decode stage for the ysyx_22050039 RV64 core. It decodes one instruction per cycle, reads operands from an internal NR_REG×XLEN register file, tracks pending destination writes in a scoreboard, and holds the decoded bundle in an output register behind a valid/ready handshake. It sits between the fetch stage (IFU) and the execute stage (EXU), and receives write-back from the end of the pipe.

## Interface
- XLEN, 64, data/register width
- INST_LEN, 32, instruction width
- NR_REG, 32, number of GPRs (x0 hardwired zero)
- REG_SEL, 5, register index width, log2(NR_REG)

- clk  input  1  clock, all state on rising edge
- rst  input  1  asynchronous, active-low reset
- in_valid  input  1  fetch offers in_inst/in_pc
- in_ready  output  1  stage accepts this cycle
- in_inst  input  INST_LEN  instruction
- in_pc  input  XLEN  instruction address
- out_valid  output  1  decoded bundle valid
- out_ready  input  1  EXU consumes bundle
- out_pc  output  XLEN  registered pc
- out_src1, out_src2  output  XLEN  operand values (0 if unused)
- out_imm  output  XLEN  sign-extended immediate
- out_rd  output  REG_SEL  destination index
- out_rd_wen  output  1  instruction writes rd (rd≠0)
- out_fmt  output  6  one-hot {R,I,S,B,U,J}
- out_opcode  output  7, out_funct3  output  3, out_funct7  output  7  raw fields
- out_ebreak  output  1  exact ebreak encoding (32'h00100073)
- out_illegal  output  1  unsupported encoding
- wb_en  input  1  write-back valid
- wb_rd  input  REG_SEL  write-back index
- wb_data  input  XLEN  write-back value
- flush  input  1  discard held bundle (redirect)

## Operation
- Supported opcodes: LUI 0110111, AUIPC 0010111 (U); JAL 1101111 (J); JALR 1100111, LOAD 0000011, OP-IMM 0010011, OP-IMM-32 0011011 (I); STORE 0100011 (S); BRANCH 1100011 (B); OP 0110011, OP-32 0111011 (R); SYSTEM exact ebreak. Anything else: out_illegal=1, out_fmt=0, out_rd_wen=0, no sources.
- Immediates to XLEN: I = sext(inst[31:20]); S = sext({inst[31:25],inst[11:7]}); B = sext({inst[31],inst[7],inst[30:25],inst[11:8],1'b0}); U = sext({inst[31:12],12'b0}); J = sext({inst[31],inst[19:12],inst[20],inst[30:21],1'b0}); R/ebreak/illegal = 0.
- rs1 used by R,I,S,B; rs2 used by R,S,B. rd written by R,I,U,J when rd≠0; never by S,B.
- Register file: x0 reads 0, writes dropped. wb_en writes regs[wb_rd] at edge.
- Bypass: a read whose index equals wb_rd while wb_en (wb_rd≠0) returns wb_data in the same cycle.
- Scoreboard busy[NR_REG]; busy[0] constant 0. hazard = (rs1 used & busy[rs1] & ¬bypass1) | (rs2 used & busy[rs2] & ¬bypass2) | (rd_wen & busy[rd] & ¬(wb_en & wb_rd==rd)).
- in_ready = (¬out_valid | out_ready) & ¬hazard & ¬flush. Accept = in_valid & in_ready: load output register, out_valid←1, set busy[rd] if rd_wen.
- Consume without accept: out_valid←0.
- Same-cycle busy set (accept) and clear (wb_en, same index): set wins.
- flush: out_valid←0; if held bundle has out_rd_wen, clear busy[out_rd]; no accept that cycle. Write-backs still apply.
- ebreak: passes through as normal bundle with out_ebreak=1.

## Timing
- Decode, register read, hazard check: combinational on in_inst; bundle latency 1 cycle.
- Write-back visible: same cycle via bypass, regs next cycle.
- Throughput 1 instr/cycle without hazards; out_valid stays asserted and outputs stay stable while out_ready=0.
- Reset (rst=0, async): out_valid=0, all out_* = 0, all regs=0, all busy=0, in_ready=0 during reset. First accept is possible on the first edge after release.

## Test plan
- Reset: rst low mid-stream -> out_valid=0, regs/busy cleared immediately; after release, x5 reads 0.
- addi x1,x0,-1 (32'hFFF00093) accepted -> next cycle out_imm=64'hFFFF_FFFF_FFFF_FFFF, out_fmt=010000, out_rd=1, out_rd_wen=1, busy[1]=1.
- RAW stall: addi x1 issued, then add x2,x1,x1 held with in_ready=0 until wb_en=1, wb_rd=1, wb_data=7 -> accepted that cycle with out_src1=out_src2=7.
- Backpressure: out_ready=0 for 3 cycles -> bundle held stable, in_ready=0; out_ready=1 -> next instruction accepted.
- Flush: held lui x3 (busy[3]=1) with flush=1 -> out_valid=0, busy[3]=0; a following add x4,x3,x0 issues without stall.
- Immediates/illegal: jal x0,-4 -> out_imm=-4; sd with offset -8 -> out_imm=-8, out_rd_wen=0; 32'h0000_0000 -> out_illegal=1; 32'h00100073 -> out_ebreak=1.
